// File: rtl/context_bank_if.sv
// context_bank_if
//   Bundles the manager request signals and the register-file port of the
//   context save/restore engine.
//   master : manager + register file side (drives Snapshot, Load_Proc,
//            Old_ID, New_ID, Rf_RData; observes the rest)
//   slave  : context_bank (drives Rf_Addr, Rf_WData, Rf_WE, Busy, Done)
//   Parameters must match the context_bank instance they connect to.
interface context_bank_if #(
  parameter int NUM_REGS  = 32,
  parameter int REG_W     = 32,
  parameter int PROC_BITS = 2
);
  localparam int AW = $clog2(NUM_REGS);

  logic                 Snapshot;
  logic                 Load_Proc;
  logic [PROC_BITS-1:0] Old_ID;
  logic [PROC_BITS-1:0] New_ID;
  logic [REG_W-1:0]     Rf_RData;
  logic [AW-1:0]        Rf_Addr;
  logic [REG_W-1:0]     Rf_WData;
  logic                 Rf_WE;
  logic                 Busy;
  logic                 Done;

  modport master (
    output Snapshot, Load_Proc, Old_ID, New_ID, Rf_RData,
    input  Rf_Addr, Rf_WData, Rf_WE, Busy, Done
  );

  modport slave (
    input  Snapshot, Load_Proc, Old_ID, New_ID, Rf_RData,
    output Rf_Addr, Rf_WData, Rf_WE, Busy, Done
  );
endinterface

// File: rtl/context_bank.sv
// context_bank
//   Register-file context save/restore engine. A rising edge on Snapshot
//   copies the live register file into context slot Old_ID, one register per
//   cycle; a rising edge on Load_Proc copies slot New_ID back into the
//   register file. A restore requested while busy is queued (pend) and runs
//   as soon as the current sequence ends, without a bubble.
//   Ports:
//     Fast_Clock : clock, all state on rising edge
//     Reset      : synchronous, active-high (context storage is not cleared)
//     bus        : context_bank_if.slave (requests, register-file port,
//                  Busy / Done status)
//   Build option:
//     CTX_SKIP_R0_EN : register 0 is hardwired zero; transfers cover
//                      registers 1..NUM_REGS-1 only.
module context_bank #(
  parameter int NUM_REGS  = 32,
  parameter int REG_W     = 32,
  parameter int PROC_BITS = 2
) (
  input logic           Fast_Clock,
  input logic           Reset,
  context_bank_if.slave bus
);
  localparam int AW    = $clog2(NUM_REGS);
  localparam int NSLOT = 2 ** PROC_BITS;
  localparam logic [AW-1:0] LAST = AW'(NUM_REGS - 1);
`ifdef CTX_SKIP_R0_EN
  localparam logic [AW-1:0] FIRST = AW'(1);
`else
  localparam logic [AW-1:0] FIRST = '0;
`endif

  typedef enum logic [1:0] {IDLE, SAVE, RESTORE, DONE} state_t;

  state_t               state_q, state_d;
  logic [AW-1:0]        idx_q, idx_d;
  logic [PROC_BITS-1:0] old_id_q, old_id_d;
  logic [PROC_BITS-1:0] new_id_q, new_id_d;
  logic                 pend_q, pend_d;
  logic                 snap_q, load_q;
  logic                 snap_edge, load_edge, pend_any;

  logic [REG_W-1:0] ctx [NSLOT][NUM_REGS];

  assign snap_edge = bus.Snapshot & ~snap_q;
  assign load_edge = bus.Load_Proc & ~load_q;
  // a restore request arriving this very cycle counts as pending too, so a
  // request on the last SAVE / the DONE cycle chains without being lost
  assign pend_any  = pend_q | load_edge;

  // Edge-detect copies track the inputs in reset as well, so a level that is
  // already high when reset releases is not seen as a new request.
  always_ff @(posedge Fast_Clock) begin
    snap_q <= bus.Snapshot;
    load_q <= bus.Load_Proc;
    if (Reset) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      pend_q   <= 1'b0;
      old_id_q <= '0;
      new_id_q <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      pend_q   <= pend_d;
      old_id_q <= old_id_d;
      new_id_q <= new_id_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    old_id_d = old_id_q;
    new_id_d = new_id_q;
    pend_d   = pend_q;
    // While busy, a restore request only queues; new_id is overwritten right
    // away, so an in-flight restore reads its remaining words from the new
    // slot before the queued restore rewrites the whole file anyway.
    if (state_q != IDLE && load_edge) begin
      pend_d   = 1'b1;
      new_id_d = bus.New_ID;
    end
    unique case (state_q)
      IDLE: begin
        if (snap_edge) begin
          state_d  = SAVE;
          old_id_d = bus.Old_ID;
          idx_d    = FIRST;
          // simultaneous requests: save first, restore queued behind it
          if (load_edge) begin
            pend_d   = 1'b1;
            new_id_d = bus.New_ID;
          end
        end else if (load_edge || pend_q) begin
          state_d = RESTORE;
          idx_d   = FIRST;
          pend_d  = 1'b0;
          if (load_edge) new_id_d = bus.New_ID;
        end
      end
      SAVE: begin
        if (idx_q == LAST) begin
          if (pend_any) begin
            state_d = RESTORE;
            idx_d   = FIRST;
            pend_d  = 1'b0;
          end else begin
            state_d = IDLE;
          end
        end else begin
          idx_d = idx_q + AW'(1);
        end
      end
      RESTORE: begin
        if (idx_q == LAST) state_d = DONE;
        else               idx_d   = idx_q + AW'(1);
      end
      DONE: begin
        if (pend_any) begin
          state_d = RESTORE;
          idx_d   = FIRST;
          pend_d  = 1'b0;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Context store: one word per SAVE cycle, suppressed in the reset cycle so
  // an aborted save leaves the untouched words as they were.
  always_ff @(posedge Fast_Clock) begin
    if (!Reset && state_q == SAVE) ctx[old_id_q][idx_q] <= bus.Rf_RData;
  end

  always_comb begin
    bus.Rf_Addr  = '0;
    bus.Rf_WData = '0;
    bus.Rf_WE    = 1'b0;
    bus.Done     = 1'b0;
    unique case (state_q)
      SAVE: bus.Rf_Addr = idx_q;
      RESTORE: begin
        bus.Rf_Addr  = idx_q;
        bus.Rf_WData = ctx[new_id_q][idx_q];
        // register 0 is never written when it is hardwired zero
        bus.Rf_WE    = (FIRST == '0) || (idx_q != '0);
      end
      DONE: bus.Done = 1'b1;
      default: ;
    endcase
  end

  assign bus.Busy = (state_q != IDLE) | pend_q;
endmodule
